// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, FSM state type and fetch buffer entry layout for the fetch stage
package fetch_pkg;
  localparam int XLEN = 32;
  localparam int INSTR_BYTES = 4;
  typedef enum logic {RUN, DRAIN} fetch_state_t;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: sync FIFO (clk, rst, flush_i, push_i/wdata_i, pop_i/rdata_o, full_o, empty_o, count_o); push allowed when full if popping, rdata_o is 0 when empty
module fetch_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     pop_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic do_push, do_pop;
  assign full_o = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign do_pop = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = empty_o ? '0 : mem_q[rd_q];
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk) if (do_push) mem_q[wr_q] <= wdata_i;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: credit-limited instruction fetch (pc_cur -> pc_next/pc_we, imem req/resp, redirect, if_* decode handshake) with RUN/DRAIN FSM
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_cur,
  output logic [XLEN-1:0] pc_next,
  output logic            pc_we,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr
);
  localparam int CW = $clog2(DEPTH) + 1;
  fetch_state_t state_q, state_d;
  logic [CW-1:0] out_q, out_d, buf_cnt, tag_cnt;
  logic active_q, accept, resp, resp_run, pop;
  logic buf_empty, buf_full, tag_empty, tag_full;
  logic [XLEN-1:0] tag_pc;
  fetch_entry_t head, wr_entry;
  logic unused;
  assign unused = ^{buf_full, tag_empty, tag_full, tag_cnt};
  assign imem_req_addr = pc_cur;
  // active_q holds requests off for one cycle after reset so the post-reset cycle is quiet
  assign imem_req_valid = ~rst & active_q & (state_q == RUN) & ~redirect_valid & ((out_q + buf_cnt) < CW'(DEPTH));
  assign accept = imem_req_valid & imem_req_ready;
  assign pc_we = ~rst & (redirect_valid | accept);
  assign pc_next = redirect_valid ? redirect_pc : pc_cur + XLEN'(INSTR_BYTES);
  // responses are only meaningful while something is outstanding
  assign resp = imem_resp_valid & (out_q != '0);
  assign resp_run = resp & (state_q == RUN);
  assign if_valid = ~rst & ~buf_empty;
  assign pop = if_valid & if_ready;
  assign if_pc = if_valid ? head.pc : '0;
  assign if_instr = if_valid ? head.instr : '0;
  assign wr_entry = '{pc: tag_pc, instr: imem_resp_data};
  assign out_d = out_q + CW'(accept) - CW'(resp);
  assign state_d = (out_d == '0) ? RUN : redirect_valid ? DRAIN : state_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      out_q <= '0;
      active_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q <= out_d;
      active_q <= 1'b1;
    end
  end
  fetch_fifo #(.W($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_buf (
    .clk(clk), .rst(rst), .flush_i(redirect_valid),
    .push_i(resp_run), .wdata_i(wr_entry), .pop_i(pop),
    .rdata_o(head), .full_o(buf_full), .empty_o(buf_empty), .count_o(buf_cnt)
  );
  fetch_fifo #(.W(XLEN), .DEPTH(DEPTH)) u_tag (
    .clk(clk), .rst(rst), .flush_i(redirect_valid),
    .push_i(accept), .wdata_i(pc_cur), .pop_i(resp_run),
    .rdata_o(tag_pc), .full_o(tag_full), .empty_o(tag_empty), .count_o(tag_cnt)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized scoreboard bench for fetch_stage against a sequential-program reference model
module tb_fetch_stage;
  localparam int DEPTH = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] pc_cur = '0, pc_next, imem_req_addr, imem_resp_data = '0, redirect_pc = '0, if_pc, if_instr;
  logic pc_we, imem_req_valid, if_valid;
  logic imem_req_ready = 1'b0, imem_resp_valid = 1'b0, redirect_valid = 1'b0, if_ready = 1'b0;
  int tests = 0, fails = 0, pops = 0, acc_cnt = 0, ifr_mode = 1;
  bit fast = 1'b1, resp_en = 1'b1;
  logic [31:0] pend_q[$];
  logic [63:0] exp_q[$];
  logic [63:0] e;
  logic [31:0] tgt;
  always #5 clk = ~clk;
  fetch_stage #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc_cur(pc_cur), .pc_next(pc_next), .pc_we(pc_we),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr)
  );
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  // expected decode stream after a (re)start at t: t, t+4, t+8 ... with the memory word at each
  task automatic load_seg(input logic [31:0] t);
    exp_q.delete();
    for (int i = 0; i < 128; i++) exp_q.push_back({t + 32'(4 * i), mem_word(t + 32'(4 * i))});
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_reset(input int n);
    rst = 1'b1;
    step(n);
    rst = 1'b0;
    load_seg(32'h0);
  endtask
  task automatic redirect(input logic [31:0] t, input int n);
    redirect_valid = 1'b1;
    redirect_pc = t;
    step(n);
    redirect_valid = 1'b0;
    load_seg(t);
  endtask
  task automatic chk_idle();
    chk("idle_if_valid", if_valid, 0);
    chk("idle_req_valid", imem_req_valid, 0);
    chk("idle_pc_we", pc_we, 0);
    chk("idle_if_pc", if_pc, 0);
    chk("idle_if_instr", if_instr, 0);
  endtask
  always @(posedge clk) if (rst) pc_cur <= '0; else if (pc_we) pc_cur <= pc_next;
  initial forever begin
    @(posedge clk);
    #2;
    imem_resp_valid = !rst && resp_en && pend_q.size() > 0 && (fast || $urandom_range(2) != 0);
    imem_resp_data = pend_q.size() > 0 ? mem_word(pend_q[0]) : 32'h0;
    imem_req_ready = fast || $urandom_range(3) != 0;
    if_ready = ifr_mode == 2 ? 1'($urandom_range(1)) : ifr_mode == 1;
  end
  always @(negedge clk) begin
    if (imem_resp_valid && pend_q.size() > 0) void'(pend_q.pop_front());
    if (rst) begin
      pend_q.delete();
      chk("rst_pc_we", pc_we, 0);
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_if_valid", if_valid, 0);
    end else begin
      if (redirect_valid) begin
        chk("redir_pc_we", pc_we, 1);
        chk("redir_pc_next", pc_next, redirect_pc);
        chk("redir_no_req", imem_req_valid, 0);
      end else if (imem_req_valid && imem_req_ready) begin
        chk("acc_pc_we", pc_we, 1);
        chk("acc_pc_next", pc_next, 32'(pc_cur + 32'd4));
        chk("acc_addr", imem_req_addr, pc_cur);
        acc_cnt++;
        pend_q.push_back(imem_req_addr);
      end else chk("idle_pc_we", pc_we, 0);
      if (if_valid && if_ready) begin
        pops++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL stream_extra: got if_pc %h, expected no entry", if_pc);
        end else begin
          e = exp_q.pop_front();
          chk("if_pc", if_pc, e[63:32]);
          chk("if_instr", if_instr, e[31:0]);
        end
      end
    end
  end
  initial begin
    do_reset(2);
    chk_idle();
    step(20);
    do_reset(1);
    chk_idle();
    ifr_mode = 0;
    acc_cnt = 0;
    step(10);
    chk("credit_accepts", acc_cnt, DEPTH);
    chk("credit_stall", imem_req_valid, 0);
    ifr_mode = 1;
    step(15);
    ifr_mode = 0;
    step(8);
    chk("full_before_rst", if_valid, 1);
    do_reset(1);
    chk_idle();
    ifr_mode = 1;
    resp_en = 1'b0;
    step(4);
    redirect(32'h100, 1);
    chk("drain_no_req", imem_req_valid, 0);
    resp_en = 1'b1;
    step(20);
    redirect(32'hFFFF_FFF8, 1);
    step(10);
    fast = 1'b0;
    ifr_mode = 2;
    for (int i = 0; i < 15; i++) begin
      step($urandom_range(30, 10));
      if (i == 7) do_reset(1);
      else begin
        case ($urandom_range(3))
          0: tgt = $urandom & 32'hFFFF_FFFC;
          1: tgt = 32'h102;
          2: tgt = 32'hFFFF_FFFC;
          default: tgt = $urandom;
        endcase
        redirect(tgt, $urandom_range(3, 1));
      end
    end
    ifr_mode = 1;
    step(30);
    chk("progress", pops >= 40, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: DEPTH, 2, fetch buffer entries and maximum outstanding-plus-buffered fetches (power of 2, ≥2).
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 pc_cur  in  32  current PC from the program counter register.
REQ-005 pc_next  out  32  next PC value driven to the program counter register input.
REQ-006 pc_we  out  1  write enable to the program counter register.
REQ-007 imem_req_valid / imem_req_ready  out / in  1 / 1  instruction-memory request handshake.
REQ-008 imem_req_addr  out  32  fetch address; equals pc_cur.
REQ-009 imem_resp_valid / imem_resp_data  in / in  1 / 32  in-order response, one per accepted request, latency ≥1 cycle.
REQ-010 redirect_valid / redirect_pc  in / in  1 / 32  branch/jump redirect from downstream.
REQ-011 if_valid / if_ready  out / in  1 / 1  decode-side handshake.
REQ-012 if_pc / if_instr  out / out  32 / 32  PC and instruction word of buffer head.

Function
REQ-013 FSM states: RUN, DRAIN.
REQ-014 Credit = DEPTH − (outstanding + buffered); imem_req_valid SHALL be 1 only in RUN, credit > 0, redirect_valid = 0.
REQ-015 Request accepted (valid & ready): pc_we = 1, pc_next = pc_cur + 4 modulo 2^32 same cycle; pc_cur pushed to an internal PC tag queue; outstanding += 1.
REQ-016 No accepted request and no redirect: pc_we = 0; pc_next = pc_cur + 4 (don't-care).
REQ-017 Response in RUN: {tag-queue head, imem_resp_data} written to buffer; outstanding −= 1; visible on if_valid next cycle (1-cycle latency from response).
REQ-018 if_valid = buffer non-empty; entry popped when if_valid & if_ready.
REQ-019 Buffer full with simultaneous pop and write: both occur; credit rule guarantees no write-when-full without pop.
REQ-020 Accept and response in same cycle: outstanding unchanged; tag queue push and pop both occur.
REQ-021 redirect_valid = 1 (any state): pc_we = 1, pc_next = redirect_pc; no request issued; buffer and tag queue flushed; if_valid = 0 next cycle.
REQ-022 Redirect with outstanding > 0 after that cycle's response: next state DRAIN; otherwise RUN.
REQ-023 DRAIN: responses discarded, outstanding decremented; no requests; transition to RUN when outstanding reaches 0.
REQ-024 Redirect has priority over accept; redirect during DRAIN keeps DRAIN and updates PC.
REQ-025 redirect_pc[1:0] ≠ 0 passed through unmodified; alignment checking out of scope.

Reset
REQ-026 On rst: state RUN, outstanding 0, buffer and tag queue empty.
REQ-027 During/after rst cycle: pc_we 0, imem_req_valid 0, if_valid 0, if_pc 0, if_instr 0.
REQ-028 Reset mid-operation: pending responses arriving after reset SHALL NOT be signaled by the environment; block ignores imem_resp_valid while outstanding = 0.

Structure
REQ-029 Package fetch_pkg: XLEN = 32, INSTR_BYTES = 4, fetch_state_t enum {RUN, DRAIN}, fetch_entry_t struct {pc, instr}.
REQ-030 One sub-module fetch_fifo (parameterized width/depth, synchronous flush, full/empty/count), instantiated for the buffer and the tag queue.

Verification
REQ-031 Reset, pc_cur = 0, imem ready, 1-cycle latency, if_ready = 1 -> pc_next 4, 8, 12...; if_pc 0, 4, 8 in order with matching instr.
REQ-032 if_ready = 0 for 10 cycles -> exactly DEPTH requests accepted, then imem_req_valid = 0; resume -> no loss or duplication.
REQ-033 Redirect to 0x100 with 2 outstanding -> pc_next 0x100, pc_we 1, DRAIN, both late responses dropped, first if_pc = 0x100.
REQ-034 pc_cur = 0xFFFF_FFFC accepted -> pc_next = 0x0000_0000.
REQ-035 Response and new accept same cycle at buffer count DEPTH−1 with pop -> counts consistent, no overflow.
REQ-036 rst asserted with buffer full -> next cycle if_valid 0, imem_req_valid 0, pc_we 0.
